// File: rtl/channel_streamer_pkg.sv
// -----------------------------------------------------------------------------
// channel_streamer_pkg
//   Shared definitions for the channel streamer: FSM state encoding, the
//   frame header constant and the number of bytes sent per channel word.
//   Build option: CHANNEL_STREAMER_HEADER_EN prefixes every frame with
//   HEADER_BYTE, making frames 5 bytes long instead of 4.
// -----------------------------------------------------------------------------
package channel_streamer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_LOAD,
        S_SEND
    } state_e;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

`ifdef CHANNEL_STREAMER_HEADER_EN
    localparam int FRAME_BYTES = 5;
`else
    localparam int FRAME_BYTES = 4;
`endif

    localparam int BYTE_IDX_W = $clog2(FRAME_BYTES);

endpackage

// File: rtl/channel_streamer_if.sv
// -----------------------------------------------------------------------------
// channel_streamer_if
//   Read port of the word channel feeding the streamer.
//     ch_available : channel holds at least one word
//     ch_data      : channel output word, valid a fixed latency after ch_read
//     ch_read      : read strobe, one word popped per rising edge
//   master : streamer side (issues ch_read)
//   slave  : channel side (supplies data)
// -----------------------------------------------------------------------------
interface channel_streamer_if;
    logic        ch_available;
    logic [31:0] ch_data;
    logic        ch_read;

    modport master (input  ch_available, input  ch_data, output ch_read);
    modport slave  (output ch_available, output ch_data, input  ch_read);
endinterface

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
//   Serialises one byte as UART 8N1: start bit (0), 8 data bits LSB first,
//   stop bit (1), each bit CLK_DIV cycles long. The line idles high.
//   Ports:
//     i_clk   : clock, rising edge
//     _mrst   : synchronous active-low reset
//     start   : load tx_byte and begin a new frame (start bit next cycle)
//     tx_byte : byte to send, sampled when start is high
//     tx      : serial line (registered)
//     done    : 1-cycle pulse in the last cycle of the stop bit; asserting
//               start in that same cycle gives back-to-back bytes
// -----------------------------------------------------------------------------
module uart_tx_byte #(
    parameter int CLK_DIV = 217
) (
    input  logic       i_clk,
    input  logic       _mrst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       done
);

    localparam int              DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]      BIT_LAST = 4'd9;  // bit 0 = start, bit 9 = stop

    if (CLK_DIV < 2) begin : g_bad_div
        $error("uart_tx_byte: CLK_DIV must be at least 2");
    end

    logic             active_q, active_d;
    logic [DIV_W-1:0] div_q,    div_d;
    logic [3:0]       bit_q,    bit_d;
    logic [8:0]       shift_q,  shift_d;   // remaining data bits + stop bit
    logic             tx_q,     tx_d;

    assign done = active_q && (bit_q == BIT_LAST) && (div_q == DIV_LAST);
    assign tx   = tx_q;

    // NOTE: every signal gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;

        if (start) begin
            active_d = 1'b1;
            div_d    = '0;
            bit_d    = '0;
            shift_d  = {1'b1, tx_byte};
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (bit_q == BIT_LAST) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block.
    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (!_mrst) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/channel_streamer.sv
// -----------------------------------------------------------------------------
// channel_streamer
//   Pops 32-bit words from a fixed-latency channel and streams each one out
//   as a UART frame of bytes, LSB byte first.
//   Build option: CHANNEL_STREAMER_HEADER_EN adds header byte 0xA5 in front
//   of every frame.
//   Ports:
//     i_clk  : clock, rising edge
//     _mrst  : synchronous active-low reset
//     en     : streaming enable, only looked at between frames
//     ch     : channel read port (ch_available, ch_data, ch_read)
//     o_tx   : UART 8N1 line, idle high
//     o_busy : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module channel_streamer
    import channel_streamer_pkg::*;
#(
    parameter int CLK_DIV      = 217,
    parameter int READ_LATENCY = 3
) (
    input  logic                i_clk,
    input  logic                _mrst,
    input  logic                en,
    channel_streamer_if.master  ch,
    output logic                o_tx,
    output logic                o_busy
);

    // Counts cycles since ch_read rose; must also reach 1 to end the strobe.
    localparam int                    LAT_W     = $clog2(READ_LATENCY + 3);
    localparam logic [BYTE_IDX_W-1:0] BYTE_LAST = BYTE_IDX_W'(FRAME_BYTES - 1);

    state_e                 state_q,    state_d;
    logic [LAT_W-1:0]       cnt_q,      cnt_d;
    logic [BYTE_IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [31:0]            word_q,     word_d;
    logic [BYTE_IDX_W-1:0]  sel_idx;
    logic                   tx_start;
    logic                   tx_done;
    logic [7:0]             tx_byte;

    // Strobe is a plain decode of the state register: high for the two REQ
    // cycles, so exactly one rising edge per word.
    assign ch.ch_read = (state_q == S_REQ);
    assign o_busy     = (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        tx_start   = 1'b0;
        sel_idx    = byte_idx_q + BYTE_IDX_W'(1);

        case (state_q)
            S_IDLE: begin
                if (en && ch.ch_available) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + LAT_W'(1);
                if (cnt_q == LAT_W'(1)) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // cnt_q equals the number of cycles since ch_read rose.
                if (cnt_q >= LAT_W'(READ_LATENCY)) begin
                    word_d  = ch.ch_data;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + LAT_W'(1);
                end
            end
            S_LOAD: begin
                tx_start   = 1'b1;
                sel_idx    = '0;
                byte_idx_d = '0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                // done marks the final stop-bit cycle; chaining start here
                // keeps bytes back-to-back.
                if (tx_done) begin
                    if (byte_idx_q == BYTE_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        tx_start   = 1'b1;
                        byte_idx_d = sel_idx;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CHANNEL_STREAMER_HEADER_EN
    logic [BYTE_IDX_W-1:0] data_idx;

    always_comb begin
        data_idx = sel_idx - BYTE_IDX_W'(1);
        if (sel_idx == '0) begin
            tx_byte = HEADER_BYTE;
        end else begin
            tx_byte = word_q[{data_idx[1:0], 3'b000} +: 8];
        end
    end
`else
    always_comb begin
        tx_byte = word_q[{sel_idx, 3'b000} +: 8];
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!_mrst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
        end
    end

    uart_tx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .i_clk   (i_clk),
        ._mrst   (_mrst),
        .start   (tx_start),
        .tx_byte (tx_byte),
        .tx      (o_tx),
        .done    (tx_done)
    );

endmodule

// File: doc/channel_streamer.md
CHANNEL_STREAMER -- requirements
Module: channel_streamer

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 217, giving i_clk cycles per UART bit (115200 baud at 25 MHz).
REQ-002 The module SHALL have parameter READ_LATENCY, default 3, giving i_clk cycles from ch_read rising to ch_data valid.
REQ-003 i_clk  input  1  system clock; all logic on rising edge.
REQ-004 _mrst  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  streaming enable.
REQ-006 ch_available  input  1  channel holds at least one word.
REQ-007 ch_data  input  32  channel output word.
REQ-008 ch_read  output  1  read strobe; the channel pops one word per rising edge.
REQ-009 o_tx  output  1  UART 8N1 serial line, idle high.
REQ-010 o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, REQ, WAIT, LOAD, SEND.
REQ-012 IDLE->REQ SHALL occur when en=1 and ch_available=1; otherwise the FSM stays in IDLE.
REQ-013 In REQ, ch_read SHALL be high for exactly 2 cycles, then the FSM SHALL enter WAIT with ch_read low.
REQ-014 WAIT SHALL last until READ_LATENCY cycles have elapsed since ch_read rose; ch_data SHALL then be captured into a 32-bit word register, and the FSM SHALL enter LOAD.
REQ-015 A frame SHALL be the 4 bytes of the word, LSB byte first (bits 7:0, 15:8, 23:16, 31:24); each byte SHALL be start bit (0), 8 data bits LSB first, and one stop bit (1).
REQ-016 Each bit SHALL last exactly CLK_DIV cycles.
REQ-017 The first start bit SHALL appear on o_tx 1 cycle after capture.
REQ-018 Bytes SHALL be back-to-back: the next start bit follows the previous stop bit with no idle cycles.
REQ-019 After the last stop bit the FSM SHALL return to IDLE, and IDLE SHALL last at least 1 cycle before the next REQ, guaranteeing a falling edge between strobes.
REQ-020 en falling mid-word SHALL NOT abort; the current frame completes, then the FSM stays in IDLE.
REQ-021 ch_available falling during REQ/WAIT SHALL NOT abort; the captured word is sent regardless.
REQ-022 The bit counter SHALL be at least clog2(CLK_DIV) bits wide; CLK_DIV < 2 is illegal.
REQ-023 Exactly one ch_read rising edge SHALL occur per transmitted word.

Reset
REQ-024 While _mrst=0 at a clock edge, the FSM SHALL go to IDLE, with o_tx=1, ch_read=0, o_busy=0 and all counters=0.
REQ-025 Reset mid-frame SHALL drive o_tx high on the next cycle; the partial word is discarded and is not re-read.

Configuration
REQ-026 With macro CHANNEL_STREAMER_HEADER_EN defined, each frame SHALL be prefixed by header byte 0xA5, giving 5 bytes per frame.
REQ-027 Without CHANNEL_STREAMER_HEADER_EN, frames SHALL be 4 bytes and no header logic SHALL exist.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the header constant 0xA5, and the bytes-per-frame constant.
REQ-029 Serialization SHALL be implemented in sub-module uart_tx_byte: inputs start and byte, outputs tx and done; done is a 1-cycle pulse at the end of the stop bit.
REQ-030 channel_streamer SHALL sequence bytes into uart_tx_byte.

Verification
REQ-031 Reset: _mrst=0 for 5 cycles, then en=1, ch_available=0 for 1000 cycles -> o_tx=1, ch_read=0, o_busy=0 throughout.
REQ-032 Single word: model the channel with latency 3 holding 0x12345678, CLK_DIV=4 -> one ch_read pulse of 2 cycles; o_tx decodes bytes 78 56 34 12 at 4 cycles/bit; 160 bit-cycles in total (no header).
REQ-033 Back-to-back: 3 words queued (0x00000001, 0xFFFFFFFF, 0x80000000) -> exactly 3 ch_read rising edges; bytes 01 00 00 00 FF FF FF FF 00 00 00 80; ch_read low for at least 1 cycle between strobes.
REQ-034 Enable drop: en deasserted during byte 2 of a frame -> frame completes all 4 bytes, then no further ch_read while words remain available.
REQ-035 Mid-frame reset: _mrst=0 for 1 cycle during a data bit -> o_tx=1 the next cycle; after release with a word available, a new frame starts with a fresh ch_read.
REQ-036 Header build: CHANNEL_STREAMER_HEADER_EN defined with word 0xDEADBEEF -> bytes A5 EF BE AD DE.
